// File: rtl/mult_hilo_ctrl.sv
// Iterative HI/LO multiply sequencer for the MIPS core: MULT/MULTU, MFHI/MFLO, MTHI/MTLO.
// Retires BITS_PER_CYCLE multiplier bits per cycle and stalls the pipeline while a product is in flight.
module mult_hilo_ctrl #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        abort,
    input  logic        rd_hi,
    input  logic        rd_lo,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam int         B      = BITS_PER_CYCLE;
    localparam int         N      = 32 / B;
    localparam logic [5:0] N_INIT = 6'(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      state_r;
    logic [63:0] acc_r;
    logic [63:0] mcand_r;
    logic [31:0] mplier_r;
    logic [5:0]  cnt_r;
    logic        sign_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic [63:0] partial_s;
    logic [63:0] product_s;
    logic [31:0] rd_data_s;
    logic        stall_s;

    // |0x80000000| stays 0x80000000 when read as unsigned, so no overflow case is needed.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic signed_op);
        logic [31:0] result;
        if (signed_op && value[31]) begin
            result = ~value + 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Partial product of the pre-shifted multiplicand and the next B multiplier bits.
    always_comb begin
        partial_s = mcand_r * 64'(mplier_r[B-1:0]);
    end

    // Final product with the sign restored.
    always_comb begin
        if (sign_r) begin
            product_s = ~acc_r + 64'd1;
        end else begin
            product_s = acc_r;
        end
    end

    // Zero-latency MFHI/MFLO read port; HI wins when both are requested.
    always_comb begin
        if (rd_hi) begin
            rd_data_s = hi_r;
        end else begin
            rd_data_s = lo_r;
        end
    end

    // Hold any HI/LO consumer or new issue while a multiply is in flight.
    always_comb begin
        stall_s = busy_r & (start | rd_hi | rd_lo | wr_hi | wr_lo);
    end

    // Sequencer FSM with the architectural HI/LO registers and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            acc_r    <= 64'd0;
            mcand_r  <= 64'd0;
            mplier_r <= 32'd0;
            cnt_r    <= 6'd0;
            sign_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wr_hi) begin
                        hi_r <= wr_data;
                    end
                    if (wr_lo) begin
                        lo_r <= wr_data;
                    end
                    if (start && !abort) begin
                        mcand_r  <= {32'd0, magnitude(op_a, is_signed)};
                        mplier_r <= magnitude(op_b, is_signed);
                        sign_r   <= is_signed & (op_a[31] ^ op_b[31]);
                        acc_r    <= 64'd0;
                        cnt_r    <= N_INIT;
                        busy_r   <= 1'b1;
                        state_r  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        acc_r    <= acc_r + partial_s;
                        mcand_r  <= mcand_r << B;
                        mplier_r <= mplier_r >> B;
                        cnt_r    <= cnt_r - 6'd1;
                        if (cnt_r == 6'd1) begin
                            state_r <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                    if (!abort) begin
                        hi_r   <= product_s[63:32];
                        lo_r   <= product_s[31:0];
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_data = rd_data_s;
    assign stall   = stall_s;
    assign hi      = hi_r;
    assign lo      = lo_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench: four sequencers (B = 1, 2, 4, 8) checked every cycle against a
// transaction-level model built on plain 64-bit multiplication and a completion countdown.
module tb_mult_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start_v;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        abort;
    logic        rd_hi;
    logic        rd_lo;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;

    logic [31:0] rd_data_o [4];
    logic [31:0] hi_o      [4];
    logic [31:0] lo_o      [4];
    logic        busy_o    [4];
    logic        stall_o   [4];
    logic        done_o    [4];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state per instance: cycles left until HI/LO update (0 = idle).
    int          m_rem  [4];
    logic [63:0] m_prod [4];
    logic [31:0] m_hi   [4];
    logic [31:0] m_lo   [4];
    logic        m_done [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mult_hilo_ctrl #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_v[g]),
            .is_signed (is_signed),
            .op_a      (op_a),
            .op_b      (op_b),
            .abort     (abort),
            .rd_hi     (rd_hi),
            .rd_lo     (rd_lo),
            .wr_hi     (wr_hi),
            .wr_lo     (wr_lo),
            .wr_data   (wr_data),
            .rd_data   (rd_data_o[g]),
            .hi        (hi_o[g]),
            .lo        (lo_o[g]),
            .busy      (busy_o[g]),
            .stall     (stall_o[g]),
            .done      (done_o[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic sgn, input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            p  = sa * sb;
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        return p;
    endfunction

    function automatic int iters(input int i);
        return 32 >> i;
    endfunction

    function automatic logic [31:0] pick_op();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_rem[i]  = 0;
            m_prod[i] = 64'd0;
            m_hi[i]   = 32'd0;
            m_lo[i]   = 32'd0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            m_done[i] = 1'b0;
            if (m_rem[i] == 0) begin
                if (wr_hi) m_hi[i] = wr_data;
                if (wr_lo) m_lo[i] = wr_data;
                if (start_v[i] && !abort) begin
                    m_rem[i]  = iters(i) + 1;
                    m_prod[i] = ref_product(is_signed, op_a, op_b);
                end
            end else if (abort) begin
                m_rem[i] = 0;
            end else begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_hi[i]   = m_prod[i][63:32];
                    m_lo[i]   = m_prod[i][31:0];
                    m_done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy[%0d]", i), 64'(busy_o[i]), 64'(m_rem[i] != 0));
            chk($sformatf("done[%0d]", i), 64'(done_o[i]), 64'(m_done[i]));
            chk($sformatf("hi[%0d]", i), 64'(hi_o[i]), 64'(m_hi[i]));
            chk($sformatf("lo[%0d]", i), 64'(lo_o[i]), 64'(m_lo[i]));
        end
    endtask

    task automatic check_comb();
        logic exp_busy;
        logic exp_stall;
        for (int i = 0; i < 4; i++) begin
            exp_busy  = (m_rem[i] != 0);
            exp_stall = exp_busy & (start_v[i] | rd_hi | rd_lo | wr_hi | wr_lo);
            chk($sformatf("stall[%0d]", i), 64'(stall_o[i]), 64'(exp_stall));
            chk($sformatf("rd_data[%0d]", i), 64'(rd_data_o[i]),
                64'(rd_hi ? m_hi[i] : m_lo[i]));
        end
    endtask

    // One clock: inputs were set at the preceding falling edge.
    task automatic tick();
        #1;
        check_comb();
        @(posedge clk);
        model_step();
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start_v   = 4'd0;
        is_signed = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        abort     = 1'b0;
        rd_hi     = 1'b0;
        rd_lo     = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        wr_data   = 32'd0;
    endtask

    task automatic issue(input logic [3:0] mask, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b);
        start_v   = mask;
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        tick();
        start_v = 4'd0;
    endtask

    task automatic run_until_idle(input int bound);
        int left;
        left = bound;
        while (left > 0 && (m_rem[0] != 0 || m_rem[1] != 0 || m_rem[2] != 0 || m_rem[3] != 0)) begin
            tick();
            left--;
        end
        chk("idle_bound", 64'(left == 0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_regs();
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned maximum on B=1: 33 cycles to result.
        issue(4'b0001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_until_idle(40);
        chk("umax_hi", 64'(hi_o[0]), 64'h0000_0000_FFFF_FFFE);
        chk("umax_lo", 64'(lo_o[0]), 64'h0000_0000_0000_0001);
        tick();

        // Signed cases on every B.
        issue(4'b1111, 1'b1, 32'hFFFF_FFFD, 32'd5);
        run_until_idle(40);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("neg3x5_hi[%0d]", i), 64'(hi_o[i]), 64'h0000_0000_FFFF_FFFF);
            chk($sformatf("neg3x5_lo[%0d]", i), 64'(lo_o[i]), 64'h0000_0000_FFFF_FFF1);
        end
        issue(4'b1111, 1'b1, 32'h8000_0000, 32'h8000_0000);
        run_until_idle(40);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("minxmin_hi[%0d]", i), 64'(hi_o[i]), 64'h0000_0000_4000_0000);
            chk($sformatf("minxmin_lo[%0d]", i), 64'(lo_o[i]), 64'h0);
        end

        // MFLO hazard right behind a MULT.
        issue(4'b0001, 1'b1, 32'd7, 32'd6);
        rd_lo = 1'b1;
        run_until_idle(40);
        #1;
        chk("hazard_stall", 64'(stall_o[0]), 64'd0);
        chk("hazard_rd", 64'(rd_data_o[0]), 64'h2A);
        rd_lo = 1'b0;
        tick();

        // Abort in CALC cycle 10 leaves HI untouched and produces no done.
        wr_hi   = 1'b1;
        wr_data = 32'h1111_1111;
        tick();
        wr_hi = 1'b0;
        issue(4'b0001, 1'b1, 32'd2, 32'd3);
        for (int k = 0; k < 9; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy_o[0]), 64'd0);
        chk("abort_hi", 64'(hi_o[0]), 64'h1111_1111);
        for (int k = 0; k < 3; k++) tick();

        // MTLO together with MULTU, then MTHI while busy.
        wr_lo   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        issue(4'b0001, 1'b0, 32'd4, 32'd4);
        wr_lo = 1'b0;
        chk("sim_lo_calc", 64'(lo_o[0]), 64'hDEAD_BEEF);
        wr_hi   = 1'b1;
        wr_data = 32'h5555_5555;
        tick();
        wr_hi = 1'b0;
        chk("sim_hi_busy", 64'(hi_o[0]), 64'h1111_1111);
        run_until_idle(40);
        chk("sim_lo_fix", 64'(lo_o[0]), 64'h10);
        chk("sim_hi_fix", 64'(hi_o[0]), 64'h0);

        // Asynchronous reset in the middle of CALC.
        issue(4'b1111, 1'b0, 32'd9, 32'd9);
        for (int k = 0; k < 3; k++) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b1111, 1'b0, 32'd1, 32'd1);
        run_until_idle(40);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_rst_lo[%0d]", i), 64'(lo_o[i]), 64'h1);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            start_v   = 4'($urandom_range(0, 15));
            is_signed = 1'($urandom_range(0, 1));
            op_a      = pick_op();
            op_b      = pick_op();
            abort     = ($urandom_range(0, 31) == 0);
            rd_hi     = ($urandom_range(0, 3) == 0);
            rd_lo     = ($urandom_range(0, 3) == 0);
            wr_hi     = ($urandom_range(0, 7) == 0);
            wr_lo     = ($urandom_range(0, 7) == 0);
            wr_data   = $urandom;
            tick();
        end
        idle_inputs();
        run_until_idle(40);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_hilo_ctrl.md
# mult_hilo_ctrl

- Multi-cycle multiply sequencer that owns the architectural HI/LO register pair for the MIPS core.
- Accepts MULT/MULTU issue from decode and computes the 64-bit product iteratively, B bits per cycle.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Asserts `stall` to hold the pipeline while a product is in flight, so the combinational ALU no longer carries a 64-bit multiplier on the critical path.

## Interface

Parameters:

- `BITS_PER_CYCLE`, default 1: multiplier bits retired per CALC cycle.
  - Legal values: 1, 2, 4, 8.
  - N = 32/BITS_PER_CYCLE iterations.

Ports:

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: issue a multiply. Sampled only in IDLE.
- `is_signed`  in  1: 1 = MULT (two's complement), 0 = MULTU. Sampled with `start`.
- `op_a`  in  32: multiplicand (rs). Sampled with `start`.
- `op_b`  in  32: multiplier (rt). Sampled with `start`.
- `abort`  in  1: pipeline flush. Cancels an in-flight multiply.
- `rd_hi`  in  1: MFHI in decode.
- `rd_lo`  in  1: MFLO in decode.
- `wr_hi`  in  1: MTHI write enable.
- `wr_lo`  in  1: MTLO write enable.
- `wr_data`  in  32: MTHI/MTLO data.
- `rd_data`  out  32: combinational. HI if `rd_hi`, else LO. `rd_hi` has priority when both are asserted.
- `hi`  out  32: architectural HI register.
- `lo`  out  32: architectural LO register.
- `busy`  out  1: high in CALC and FIX.
- `stall`  out  1: combinational: `busy & (start | rd_hi | rd_lo | wr_hi | wr_lo)`.
- `done`  out  1: one-cycle pulse after HI/LO are updated by a multiply.

## Operation

States:

- IDLE: waits for `start`.
- CALC: iterative shift-add loop.
- FIX: sign correction and HI/LO write.

IDLE:

- On `start`, latch magnitudes |op_a| and |op_b| when `is_signed`, raw values otherwise.
- Latch the result sign as `is_signed & (op_a[31] ^ op_b[31])`.
- Clear the 64-bit accumulator, load the counter with N, go to CALC.
- |0x80000000| = 0x80000000 as an unsigned 32-bit value; no overflow special-case.

CALC, each cycle:

- Add op_a × (low B bits of the multiplier) into the accumulator at the current bit offset.
- Shift the multiplier right by B and decrement the counter.
- Go to FIX when the counter reaches 1.

FIX:

- Two's-complement negate the 64-bit accumulator when the sign bit is set.
- Write HI = product[63:32] and LO = product[31:0].
- Go to IDLE and set `done` for the next cycle.

Abort:

- `abort` in CALC or FIX returns to IDLE at the next edge.
- HI/LO are left unchanged and no `done` pulse is produced.
- `abort` in IDLE has no effect.

MTHI/MTLO:

- `wr_hi`/`wr_lo` in IDLE write `wr_data` at the edge.
- While busy they are ignored and `stall` is held high; the pipeline re-presents them.

Simultaneous events:

- `start` + `wr_hi`/`wr_lo` in IDLE: both take effect. The write lands now; the product overwrites HI/LO at FIX.
- `start` + `abort` in IDLE: `start` is not accepted and the state stays IDLE.
- `start` while busy: ignored, `stall` is asserted.

Arithmetic:

- All internal sums are unsigned and 64 bits wide, modulo 2^64.
- The accumulator never overflows for unsigned 32×32 products.

## Timing

Reset (while `rst_n` = 0):

- State = IDLE.
- `hi` = `lo` = 0.
- `busy` = `done` = 0.
- Accumulator and counter = 0.
- Reset takes effect immediately, including mid-CALC.

Multiply sequence, with `start` accepted at edge t:

- `busy` = 1 from t through edge t+N+1.
- CALC occupies edges t+1 .. t+N; FIX occurs at edge t+N+1.
- `hi`/`lo` hold the new product after edge t+N+1.
- At that same edge `busy` falls and `done` rises; `done` falls at edge t+N+2.

Latency from issue to result:

- B=1: 33 cycles.
- B=8: 5 cycles.

Reads:

- `rd_data` has zero-cycle latency.
- A read issued while busy sees `stall` = 1 until the cycle `busy` falls.
- In that cycle `rd_data` already reflects the new product.

Back-to-back:

- A new `start` can be accepted in the cycle `done` is high (state is IDLE).

## Test plan

- Unsigned max: MULTU 0xFFFFFFFF × 0xFFFFFFFF, B=1 → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, one `done` pulse.
- Signed mixed: MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000. Repeat both for B=1, 2, 4, 8.
- Hazard: MULT 7 × 6, then `rd_lo` asserted on the next cycle → `stall` high until `busy` falls, then `rd_data`=0x0000002A with `stall` low.
- Abort: HI=0x11111111 via MTHI. MULT 2 × 3, then `abort` at CALC cycle 10 → IDLE next edge, HI=0x11111111 unchanged, no `done`.
- Simultaneous: in IDLE, `wr_lo`=0xDEADBEEF together with MULTU 4 × 4 → LO=0xDEADBEEF during CALC, LO=0x00000010 after FIX. `wr_hi` while busy → `stall` high, HI unchanged.
- Reset mid-op: `rst_n` low during CALC → `hi`=`lo`=0, `busy`=`done`=0 immediately. After release, a new MULTU 1 × 1 yields LO=1.
